// File: rtl/task_responder_if.sv
// Task-protocol bus bundle: issuer side (opcode/wdata/task_valid/ready),
// destination side (dst_*) and response side (rsp_*).
// master: the environment (issuer + destinations + response consumer).
// slave:  the task responder.
interface task_responder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [4:0]            opcode;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  task_valid;
  logic                  ready;
  logic [2:0]            dst_req;
  logic                  dst_rw;
  logic [1:0]            dst_id;
  logic [DATA_WIDTH-1:0] dst_wdata;
  logic [2:0]            dst_ack;
  logic [DATA_WIDTH-1:0] dst_rdata;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output opcode, wdata, task_valid, dst_ack, dst_rdata,
    input  ready, dst_req, dst_rw, dst_id, dst_wdata,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  opcode, wdata, task_valid, dst_ack, dst_rdata,
    output ready, dst_req, dst_rw, dst_id, dst_wdata,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/task_responder.sv
// Target-side endpoint of the OPCODE/WDATA/READY task protocol.
// Accepts one task, dispatches it over req/ack to IO, ALU or Memory and
// returns a one-cycle response. All outputs are registered.
// Optional: define TASK_RESPONDER_TIMEOUT_EN to abort a dispatch with an
// error after TIMEOUT_CYCLES request cycles without an ack; without it the
// responder waits indefinitely.
module task_responder #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 a_rst,
  task_responder_if.slave      bus,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] task_cnt
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("task_responder: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_d;
  logic [2:0]            dst_req_d;
  logic                  rsp_valid_d;
  logic [1:0]            rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  rsp_err_d;
  logic                  accept;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic [1:0]            dest;

  assign dest    = bus.opcode[2:1];
  // ready is only ever high in IDLE, so it alone qualifies an accept
  assign accept  = bus.ready & bus.task_valid;
  // dst_req is one-hot on the selected destination; other acks mask out
  assign ack_hit = |(bus.dst_ack & bus.dst_req);
  assign state   = state_q;

`ifdef TASK_RESPONDER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // Wait counter: counts request cycles without ack, cleared outside DISPATCH
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst)
      wait_cnt <= '0;
    else if (state_q == DISPATCH && state_d == DISPATCH)
      wait_cnt <= wait_cnt + 8'd1;
    else
      wait_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    dst_req_d   = bus.dst_req;
    rsp_valid_d = 1'b0;
    rsp_id_d    = bus.rsp_id;
    rsp_data_d  = bus.rsp_data;
    rsp_err_d   = bus.rsp_err;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dest == 2'd3) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = bus.opcode[4:3];
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = DISPATCH;
            dst_req_d = 3'(3'b001 << dest);
          end
        end
      end
      DISPATCH: begin
        // ack has priority over a timeout on the same edge
        if (ack_hit) begin
          state_d     = RESP;
          dst_req_d   = '0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = bus.dst_id;
          rsp_data_d  = bus.dst_rw ? bus.dst_wdata : bus.dst_rdata;
          rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          dst_req_d   = '0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = bus.dst_id;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Registered outputs, task latch and response counter
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      bus.ready     <= 1'b0;
      bus.dst_req   <= '0;
      bus.dst_rw    <= 1'b0;
      bus.dst_id    <= '0;
      bus.dst_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      task_cnt      <= '0;
    end else begin
      bus.ready     <= ready_d;
      bus.dst_req   <= dst_req_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_id    <= rsp_id_d;
      bus.rsp_data  <= rsp_data_d;
      bus.rsp_err   <= rsp_err_d;
      if (accept) begin
        bus.dst_rw    <= bus.opcode[0];
        bus.dst_id    <= bus.opcode[4:3];
        bus.dst_wdata <= bus.wdata;
      end
      if (rsp_valid_d)
        task_cnt <= task_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_task_responder.sv
// Directed self-checking bench for task_responder.
module tb_task_responder;
  localparam int DW = 8;

  logic       clk   = 1'b0;
  logic       a_rst = 1'b0;
  logic [1:0] state;
  logic [7:0] task_cnt;
  int         tests_run    = 0;
  int         tests_failed = 0;

  task_responder_if #(.DATA_WIDTH(DW)) bus ();

  task_responder #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (8)
  ) dut (
    .clk     (clk),
    .a_rst   (a_rst),
    .bus     (bus.slave),
    .state   (state),
    .task_cnt(task_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a task in a ready cycle; returns in the cycle after the accept edge
  task automatic start(input logic [4:0] op, input logic [7:0] wd);
    check("start_ready", bus.ready, 1);
    bus.opcode     = op;
    bus.wdata      = wd;
    bus.task_valid = 1'b1;
    tick();
    bus.task_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         issued;
    int         got;
    int         cyc;
    int         sched;
    int         last_rsp_cyc;
    logic [4:0] op;
    logic [7:0] wd;
    logic [1:0] exp_id;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [2:0] exp_req;

    bus.opcode     = '0;
    bus.wdata      = '0;
    bus.task_valid = 1'b0;
    bus.dst_ack    = '0;
    bus.dst_rdata  = '0;

    // reset
    tick();
    tick();
    check("rst_ready", bus.ready, 0);
    check("rst_dst_req", bus.dst_req, 0);
    check("rst_dst_rw", bus.dst_rw, 0);
    check("rst_dst_id", bus.dst_id, 0);
    check("rst_dst_wdata", bus.dst_wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_state", state, 0);
    check("rst_task_cnt", task_cnt, 0);
    a_rst = 1'b1;
    tick();
    check("rel_ready", bus.ready, 1);
    check("rel_state", state, 0);
    check("rel_task_cnt", task_cnt, 0);

    // ALU read, ack on first request cycle
    start(5'b10010, 8'h00);
    check("alu_req", bus.dst_req, 3'b010);
    check("alu_rw", bus.dst_rw, 0);
    check("alu_id", bus.dst_id, 2);
    check("alu_ready_low", bus.ready, 0);
    check("alu_state", state, 1);
    bus.dst_ack   = 3'b010;
    bus.dst_rdata = 8'hA5;
    tick();
    bus.dst_ack = '0;
    check("alu_req_off", bus.dst_req, 0);
    check("alu_rsp_valid", bus.rsp_valid, 1);
    check("alu_rsp_id", bus.rsp_id, 2);
    check("alu_rsp_data", bus.rsp_data, 8'hA5);
    check("alu_rsp_err", bus.rsp_err, 0);
    check("alu_task_cnt", task_cnt, 1);
    check("alu_state_resp", state, 2);
    check("alu_ready_resp", bus.ready, 0);
    tick();
    check("alu_ready_back", bus.ready, 1);
    check("alu_rsp_pulse", bus.rsp_valid, 0);
    check("alu_rsp_hold", bus.rsp_data, 8'hA5);

    // Memory write, ack on 4th request cycle, stray acks on other bits
    start(5'b01101, 8'h3C);
    bus.wdata     = 8'hFF;
    bus.dst_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check("mem_req", bus.dst_req, 3'b100);
      check("mem_wdata", bus.dst_wdata, 8'h3C);
      check("mem_rw", bus.dst_rw, 1);
      check("mem_id", bus.dst_id, 1);
      bus.dst_ack = (i == 3) ? 3'b100 : 3'b011;
      tick();
    end
    bus.dst_ack = '0;
    check("mem_rsp_valid", bus.rsp_valid, 1);
    check("mem_rsp_id", bus.rsp_id, 1);
    check("mem_rsp_data", bus.rsp_data, 8'h3C);
    check("mem_rsp_err", bus.rsp_err, 0);
    check("mem_task_cnt", task_cnt, 2);
    check("mem_req_off", bus.dst_req, 0);
    tick();
    check("mem_ready_back", bus.ready, 1);

    // Illegal destination
    start(5'b11110, 8'h99);
    check("ill_req", bus.dst_req, 0);
    check("ill_rsp_valid", bus.rsp_valid, 1);
    check("ill_rsp_id", bus.rsp_id, 3);
    check("ill_rsp_err", bus.rsp_err, 1);
    check("ill_rsp_data", bus.rsp_data, 0);
    check("ill_task_cnt", task_cnt, 3);
    check("ill_state", state, 2);
    tick();
    check("ill_ready_back", bus.ready, 1);
    check("ill_rsp_pulse", bus.rsp_valid, 0);
    check("ill_err_hold", bus.rsp_err, 1);
    check("ill_req_none", bus.dst_req, 0);

    // IO read with no ack
    start(5'b01000, 8'h5A);
    check("to_req_on", bus.dst_req, 3'b001);
`ifdef TASK_RESPONDER_TIMEOUT_EN
    n = 0;
    while (bus.dst_req == 3'b001 && n < 40) begin
      n++;
      tick();
    end
    check("to_req_cycles", n, 16);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_data", bus.rsp_data, 0);
    check("to_rsp_id", bus.rsp_id, 1);
    check("to_task_cnt", task_cnt, 4);
    tick();
    check("to_ready_back", bus.ready, 1);
    start(5'b10011, 8'h42);
    tick();
    exp_req = 3'b010;
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.dst_req == 3'b001) n++;
      tick();
    end
    check("hang_req_cycles", n, 100);
    check("hang_state", state, 1);
    check("hang_no_rsp", bus.rsp_valid, 0);
    exp_req = 3'b001;
`endif

    // Reset mid-DISPATCH
    check("mid_req_on", bus.dst_req, exp_req);
    #2;
    a_rst = 1'b0;
    #1;
    check("mid_req_async", bus.dst_req, 0);
    check("mid_state", state, 0);
    check("mid_ready", bus.ready, 0);
    check("mid_rsp_valid", bus.rsp_valid, 0);
    tick();
    tick();
    check("mid_rsp_valid_hold", bus.rsp_valid, 0);
    a_rst = 1'b1;
    tick();
    check("mid_ready_back", bus.ready, 1);
    check("mid_rsp_none", bus.rsp_valid, 0);
    check("mid_task_cnt", task_cnt, 0);

    // 256 back-to-back tasks with immediate ack; counter wraps to 0
    issued       = 0;
    got          = 0;
    cyc          = 0;
    sched        = 0;
    last_rsp_cyc = -1;
    exp_id       = '0;
    exp_data     = '0;
    exp_err      = 1'b0;
    bus.task_valid = 1'b1;
    while (got < 256 && cyc < 4000) begin
      if (bus.rsp_valid) begin
        check("b2b_rsp_id", bus.rsp_id, exp_id);
        check("b2b_rsp_data", bus.rsp_data, exp_data);
        check("b2b_rsp_err", bus.rsp_err, exp_err);
        got++;
        last_rsp_cyc = cyc;
      end
      bus.dst_ack = bus.dst_req;
      if (bus.ready && issued < 256) begin
        op = 5'($urandom);
        wd = 8'($urandom);
        bus.opcode    = op;
        bus.wdata     = wd;
        bus.dst_rdata = ~wd;
        exp_id   = op[4:3];
        exp_err  = (op[2:1] == 2'd3);
        exp_data = exp_err ? 8'h00 : (op[0] ? wd : ~wd);
        sched    = sched + (exp_err ? 2 : 3);
        issued++;
      end else if (issued == 256) begin
        bus.task_valid = 1'b0;
      end
      if (got < 256) begin
        tick();
        cyc++;
      end
    end
    bus.task_valid = 1'b0;
    bus.dst_ack    = '0;
    check("b2b_done", got, 256);
    check("b2b_timing", last_rsp_cyc, sched - 1);
    tick();
    check("b2b_task_cnt_wrap", task_cnt, 0);
    check("b2b_ready", bus.ready, 1);
    check("b2b_req_idle", bus.dst_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
